mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It owns the HI/LO architectural registers.
- Executes MULT, MULTU, DIV, DIVU over several cycles; executes MTHI and MTLO in one cycle.
- Drives a stall request to the hazard logic whenever the pipeline needs HI/LO, or a new HI/LO op, while an operation is in flight.
- Parametrised in operand width and bits retired per cycle.

---
 rtl/mult_div_unit_pkg.sv | 27 ++
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit_md_iter_step.sv | 35 +++
 rtl/mult_div_unit.sv | 134 +++++++++++++
 tb/tb_mult_div_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared op/state encodings for the multiply/divide unit
package mult_div_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_MULT  = 3'd0;
    localparam op_t OP_MULTU = 3'd1;
    localparam op_t OP_DIV   = 3'd2;
    localparam op_t OP_DIVU  = 3'd3;
    localparam op_t OP_MTHI  = 3'd4;
    localparam op_t OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_t;

    function automatic logic is_muldiv(op_t op);
        return op <= OP_DIVU;
    endfunction

    function automatic logic is_signed_op(op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the EX stage and the HI/LO unit
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    op_t              op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             rd_req;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opa, opb, flush, rd_req,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, flush, rd_req,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit_md_iter_step.sv
// rtl/mult_div_unit_md_iter_step.sv - one bit of shift-add multiply or restoring shift-subtract divide
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Multiply: LO holds the unconsumed multiplier bits, product shifts in from the top.
    assign w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    // Divide: LO holds the unconsumed dividend bits and collects quotient bits at the bottom.
    assign w_shifted = {i_hi, i_lo[WIDTH-1]};
    assign w_ge      = w_shifted >= {1'b0, i_b};
    assign w_diff    = w_shifted[WIDTH-1:0] - i_b;

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_shifted[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO and stall request
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mult_div_unit_if.slave  bus
);
    localparam int N  = WIDTH / UNROLL;
    localparam int CW = $clog2(N + 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi_acc;
    logic [WIDTH-1:0] r_lo_acc;
    logic [WIDTH-1:0] r_b;
    logic             r_is_div;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0]   w_hi [UNROLL+1];
    logic [WIDTH-1:0]   w_lo [UNROLL+1];
    logic               w_sign_a;
    logic               w_sign_b;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_hi[0] = r_hi_acc;
    assign w_lo[0] = r_lo_acc;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        md_iter_step #(.WIDTH(WIDTH)) u_step (
            .i_is_div (r_is_div),
            .i_hi     (w_hi[g]),
            .i_lo     (w_lo[g]),
            .i_b      (r_b),
            .o_hi     (w_hi[g+1]),
            .o_lo     (w_lo[g+1])
        );
    end

    assign w_sign_a = is_signed_op(bus.op) & bus.opa[WIDTH-1];
    assign w_sign_b = is_signed_op(bus.op) & bus.opb[WIDTH-1];

    // Unsigned ops latch zero signs, so the corrections below are no-ops for them.
    assign w_neg  = r_sign_a ^ r_sign_b;
    assign w_prod = w_neg ? -{r_hi_acc, r_lo_acc} : {r_hi_acc, r_lo_acc};
    assign w_quo  = r_b_zero ? '1 : (w_neg ? -r_lo_acc : r_lo_acc);
    assign w_rem  = r_sign_a ? -r_hi_acc : r_hi_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi_acc <= '0;
            r_lo_acc <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        if (is_muldiv(bus.op)) begin
                            r_hi_acc <= '0;
                            r_lo_acc <= w_sign_a ? -bus.opa : bus.opa;
                            r_b      <= w_sign_b ? -bus.opb : bus.opb;
                            r_sign_a <= w_sign_a;
                            r_sign_b <= w_sign_b;
                            r_b_zero <= (bus.opb == '0);
                            r_is_div <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                            r_cnt    <= CW'(N);
                            r_busy   <= 1'b1;
                            r_state  <= ST_CALC;
                        end else if (bus.op == OP_MTHI) begin
                            r_hi <= bus.opa;
                        end else if (bus.op == OP_MTLO) begin
                            r_lo <= bus.opa;
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_hi_acc <= w_hi[UNROLL];
                        r_lo_acc <= w_lo[UNROLL];
                        r_cnt    <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.stall = r_busy & (bus.start | bus.rd_req);
    assign bus.done  = r_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W = 32;
    localparam int N = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus();

    mult_div_unit #(.WIDTH(W), .UNROLL(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (op)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = 64'(a) * 64'(b);
            OP_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic issue(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] m;
        exp_t        e;
        int          lat, bn;
        m = model(op, a, b);
        sb_q.push_back('{hi: m[63:32], lo: m[31:0]});
        issue(op, a, b);
        wait_done(lat, bn);
        check({tag, " latency"}, 64'(lat), 64'(N + 1));
        check({tag, " busy_cycles"}, 64'(bn), 64'(N + 1));
        check({tag, " busy_in_done"}, 64'(bus.busy), 64'(0));
        e = sb_q.pop_front();
        check({tag, " hi"}, 64'(bus.hi), 64'(e.hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(e.lo));
    endtask

    initial begin
        int lat, bad, seen;
        bus.start  = 1'b0;
        bus.op     = OP_MULT;
        bus.opa    = '0;
        bus.opb    = '0;
        bus.flush  = 1'b0;
        bus.rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset hi", 64'(bus.hi), 64'(0));
        check("reset lo", 64'(bus.lo), 64'(0));
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg3x7 const hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_neg3x7 const lo", 64'(bus.lo), 64'hFFFF_FFEB);
        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max const hi", 64'(bus.hi), 64'hFFFF_FFFE);
        do_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7by2 const lo", 64'(bus.lo), 64'hFFFF_FFFD);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf const lo", 64'(bus.lo), 64'h8000_0000);
        do_op("divu_by0", OP_DIVU, 32'd100, 32'd0);
        check("divu_by0 const hi", 64'(bus.hi), 64'h64);
        do_op("div_neg_by0", OP_DIV, 32'hFFFF_FF00, 32'd0);
        do_op("div_negneg", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        for (int i = 0; i < 4; i++)
            do_op($sformatf("rand%0d", i), op_t'(i), $urandom, 32'($urandom_range(1, 1000)));

        // RdReq held over a whole MULT, with a second Start injected mid-op.
        bus.rd_req = 1'b1;
        issue(OP_MULT, 32'd3, 32'd4);
        lat = 0;
        bad = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.stall !== 1'b1) bad++;
            if (lat == 10) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.opa   = 32'd9;
                bus.opb   = 32'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("rdreq stall_while_busy", 64'(bad), 64'(0));
        check("rdreq latency", 64'(lat), 64'(N + 1));
        check("rdreq stall_in_done", 64'(bus.stall), 64'(0));
        check("rdreq hi", 64'(bus.hi), 64'(0));
        check("rdreq lo", 64'(bus.lo), 64'(12));
        bus.rd_req = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy === 1'b1 || bus.done === 1'b1) seen++;
        end
        check("second_start ignored", 64'(seen), 64'(0));
        check("second_start lo", 64'(bus.lo), 64'(12));

        issue(OP_MTLO, 32'h1234, 32'd0);
        check("mtlo lo", 64'(bus.lo), 64'h1234);
        check("mtlo busy", 64'(bus.busy), 64'(0));
        check("mtlo done", 64'(bus.done), 64'(0));
        issue(OP_MTHI, 32'hABCD, 32'd0);
        check("mthi hi", 64'(bus.hi), 64'hABCD);
        check("mthi lo kept", 64'(bus.lo), 64'h1234);

        issue(3'd6, 32'h5555, 32'h1);
        check("undef busy", 64'(bus.busy), 64'(0));
        check("undef hilo", {32'(bus.hi), 32'(bus.lo)}, {32'hABCD, 32'h1234});

        bus.flush = 1'b1;
        issue(OP_MULT, 32'd5, 32'd6);
        bus.flush = 1'b0;
        check("flush_idle busy", 64'(bus.busy), 64'(0));

        issue(OP_MULT, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        check("flush_calc busy_before", 64'(bus.busy), 64'(1));
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        check("flush_calc no_done", 64'(seen), 64'(0));
        check("flush_calc hilo", {32'(bus.hi), 32'(bus.lo)}, {32'hABCD, 32'h1234});

        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid hi", 64'(bus.hi), 64'(0));
        check("reset_mid lo", 64'(bus.lo), 64'(0));
        check("reset_mid busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("after_reset", OP_DIVU, 32'd1000, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
